// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Iterative restoring divider for the execute stage. Produces one quotient bit
// per cycle and handles signed/unsigned DIV/REM with RISC-V M semantics for
// divide-by-zero and signed overflow.
//
// Ports:
//   clk          - clock, all state changes on rising edge
//   rst          - synchronous active-high reset
//   start        - request, honoured in IDLE or DONE only
//   is_signed    - 1: DIV/REM, 0: DIVU/REMU (latched with start)
//   dividend     - numerator (latched with start)
//   divisor      - denominator (latched with start)
//   busy         - high while iterating
//   done         - one-cycle strobe, results valid in that cycle
//   quotient     - registered quotient, held until the next done
//   remainder    - registered remainder, held until the next done
//   div_by_zero  - registered divide-by-zero flag, valid with done
//
// States:
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | iterating while cnt != 0; cnt == 0 publishes results
//   DONE   | done strobe cycle; a new start is accepted here too
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ITER = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic             qneg;
  logic             rneg;
  logic             dbz_pend;

  logic             dvd_neg;
  logic             dsr_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic             dsr_zero;
  logic             sgn_ovf;
  logic [WIDTH+1:0] trial;

  always_comb begin
    dvd_neg  = is_signed & dividend[WIDTH-1];
    dsr_neg  = is_signed & divisor[WIDTH-1];
    dvd_mag  = dvd_neg ? (~dividend + 1'b1) : dividend;
    dsr_mag  = dsr_neg ? (~divisor + 1'b1) : divisor;
    dsr_zero = (divisor == '0);
    sgn_ovf  = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
               (divisor == '1);
    // Shifted partial remainder can reach 2*divisor, so keep two guard bits
    // to make the sign of the trial subtraction exact for unsigned operands.
    trial    = {1'b0, rem, quo[WIDTH-1]} - {2'b00, dsr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      quo         <= '0;
      rem         <= '0;
      dsr         <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
      dbz_pend    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            state    <= S_RUN;
            dbz_pend <= dsr_zero;
            if (dsr_zero) begin
              // Special cases park final values in quo/rem and skip iteration
              quo  <= '1;
              rem  <= dividend;
              qneg <= 1'b0;
              rneg <= 1'b0;
              cnt  <= '0;
              busy <= 1'b0;
            end else if (sgn_ovf) begin
              quo  <= {1'b1, {(WIDTH-1){1'b0}}};
              rem  <= '0;
              qneg <= 1'b0;
              rneg <= 1'b0;
              cnt  <= '0;
              busy <= 1'b0;
            end else begin
              quo  <= dvd_mag;
              rem  <= '0;
              dsr  <= dsr_mag;
              qneg <= dvd_neg ^ dsr_neg;
              rneg <= dvd_neg;
              cnt  <= ITER;
              busy <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end

        S_RUN: begin
          if (cnt != '0) begin
            if (trial[WIDTH+1]) begin
              rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
            end else begin
              rem <= trial[WIDTH-1:0];
            end
            quo <= {quo[WIDTH-2:0], ~trial[WIDTH+1]};
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              busy <= 1'b0;
            end
          end else begin
            quotient    <= qneg ? (~quo + 1'b1) : quo;
            remainder   <= rneg ? (~rem + 1'b1) : rem;
            div_by_zero <= dbz_pend;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one start pulse (accepted at the next edge) and scrambles the
  // inputs afterwards; the expected result goes on the scoreboard.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input logic z);
    exp_t e;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    e.q = q;
    e.r = r;
    e.z = z;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start     = 1'b0;
    is_signed = 1'($urandom_range(0, 1));
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  // Counts edges until done, checking latency, busy cycles, output hold,
  // then pops the scoreboard and compares results.
  task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
    int          n;
    int          nb;
    int          unstable;
    bit          seen;
    logic [31:0] hq;
    logic [31:0] hr;
    exp_t        e;
    n = 0; nb = 0; unstable = 0; seen = 1'b0;
    hq = quotient;
    hr = remainder;
    while (!seen && n < 80) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) nb++;
      if (done) seen = 1'b1;
      else if (quotient !== hq || remainder !== hr) unstable++;
    end
    check({name, " latency"}, 32'(seen ? n : -1), 32'(exp_lat));
    check({name, " busy_cycles"}, 32'(nb), 32'(exp_busy));
    check({name, " hold_glitches"}, 32'(unstable), 32'd0);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s scoreboard: got done with empty queue expected entry", name);
    end else begin
      e = sb.pop_front();
      check({name, " quotient"}, quotient, e.q);
      check({name, " remainder"}, remainder, e.r);
      check({name, " div_by_zero"}, 32'(div_by_zero), 32'(e.z));
    end
  endtask

  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 33};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 33};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1};
    vecs[5]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1};
    vecs[6]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1};
    vecs[7]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 33};
    vecs[8]  = '{1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0, 33};
    vecs[9]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 33};
    vecs[10] = '{1'b0, 32'd1,          32'hFFFFFFFF,   32'd0,          32'd1,          1'b0, 33};
    vecs[11] = '{1'b1, 32'd0,          32'hFFFFFFFF,   32'd0,          32'd0,          1'b0, 33};

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
      check($sformatf("vec%0d busy_after_accept", i), 32'(busy), 32'(vecs[i].lat == 33));
      wait_done($sformatf("vec%0d", i), vecs[i].lat, (vecs[i].lat == 33) ? 31 : 0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d done_single", i), 32'(done), 32'd0);
    end

    // start while iterating is ignored
    launch(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore_start", 22, 20);
    @(posedge clk);
    #1;

    // back-to-back: start during the done cycle
    launch(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    wait_done("b2b_a", 33, 31);
    launch(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    check("b2b busy_no_gap", 32'(busy), 32'd1);
    wait_done("b2b_b", 33, 31);
    @(posedge clk);
    #1;

    // reset mid-run, asserted together with start
    launch(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk);
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort quotient", quotient, 32'd0);
    check("abort remainder", remainder, 32'd0);
    check("abort div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    sb.delete();
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("abort no_done", 32'(ndone), 32'd0);
    launch(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    wait_done("after_reset", 33, 31);

    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
